// File: rtl/irq_arbiter_pkg.sv
// lib_irq: shared state type and r_data word formatting for irq_arbiter.
// The tag byte is only non-zero when irq_arbiter is built with IRQ_ARBITER_TAG_EN.
package lib_irq;

    typedef enum logic {IDLE, PRESENT} irq_state_t;

    localparam int TAG_LSB = 24;

    // Payload sits in the low 24 bits; the tag byte rides on top for the CPU to decode.
    function automatic logic [31:0] fmt_payload(input logic [TAG_LSB-1:0] p24,
                                                input logic [7:0]         tag);
        logic [31:0] word;
        word                 = '0;
        word[TAG_LSB-1:0]    = p24;
        word[TAG_LSB +: 8]   = tag;
        return word;
    endfunction

endpackage

// File: rtl/irq_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker returning the first set request bit
// found scanning upward from ptr, wrapping from N_SRC-1 back to 0.
module rr_pick #(
    parameter int N_SRC = 4,
    parameter int PTR_W = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic             any,
    output logic [PTR_W-1:0] idx
);

    // cand carries one extra bit so ptr+k can exceed N_SRC-1 before the wrap.
    always_comb begin
        logic [PTR_W:0] cand;
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int k = 0; k < N_SRC; k++) begin
            cand = {1'b0, ptr} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(N_SRC)) begin
                cand = cand - (PTR_W+1)'(N_SRC);
            end
            if (!any && req[cand[PTR_W-1:0]]) begin
                any = 1'b1;
                idx = cand[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/irq_arbiter.sv
// irq_arbiter: shares the CPU irr/ack/r_data channel between N_SRC one-entry source buffers.
// Define IRQ_ARBITER_TAG_EN to expose the granted source index in r_data[31:24].
module irq_arbiter
    import lib_irq::*;
#(
    parameter int N_SRC  = 4,
    parameter int DATA_W = 24
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_SRC-1:0]        src_valid,
    input  logic [N_SRC*DATA_W-1:0] src_data,
    output logic [N_SRC-1:0]        src_ready,
    output logic                    irr,
    input  logic                    ack,
    output logic [31:0]             r_data
);

    localparam int PTR_W = $clog2(N_SRC);

    logic [DATA_W-1:0] payload_q [N_SRC];
    logic [N_SRC-1:0]  pending;
    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  grant;
    logic [PTR_W-1:0]  pick_idx;
    logic              pick_any;
    logic [7:0]        tag_w;
    irq_state_t        state;

    assign src_ready = ~pending & {N_SRC{~reset}};

`ifdef IRQ_ARBITER_TAG_EN
    assign tag_w = 8'(pick_idx);
`else
    assign tag_w = 8'h00;
`endif

    rr_pick #(.N_SRC(N_SRC)) u_pick (
        .req (pending),
        .ptr (rr_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    // Capture and clear never hit the same bit in one edge: capture needs it free, clear needs it busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
            rr_ptr  <= '0;
            grant   <= '0;
            state   <= IDLE;
            irr     <= 1'b0;
            r_data  <= '0;
            for (int i = 0; i < N_SRC; i++) begin
                payload_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                if (src_valid[i] && src_ready[i]) begin
                    payload_q[i] <= src_data[i*DATA_W +: DATA_W];
                    pending[i]   <= 1'b1;
                end
            end
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant  <= pick_idx;
                        r_data <= fmt_payload(24'(payload_q[pick_idx]), tag_w);
                        irr    <= 1'b1;
                        state  <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (ack) begin
                        pending[grant] <= 1'b0;
                        rr_ptr         <= (grant == PTR_W'(N_SRC-1)) ? '0 : grant + PTR_W'(1);
                        irr            <= 1'b0;
                        state          <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule
